// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers for the fifo family
package fifo_pkg;

  // Bits needed to encode 0..value-1; never less than one bit.
  function automatic int clogb2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  function automatic int ptr_width(input int depth);
    return clogb2(depth);
  endfunction

  function automatic int level_width(input int depth);
    return clogb2(depth + 1);
  endfunction

  localparam int DEFAULT_DEPTH     = 640;
  localparam int DEFAULT_PTR_WIDTH = ptr_width(DEFAULT_DEPTH);
  localparam int DEFAULT_LVL_WIDTH = level_width(DEFAULT_DEPTH);

endpackage

// File: rtl/bram_sd.sv
// rtl/bram_sd.sv - simple dual-port RAM with one-cycle registered read
module bram_sd #(
  parameter int DATA_DEPTH = 640,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO over bram_sd with
// a one-entry RAM read stage and a registered head-of-queue output
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_DEPTH       = DEFAULT_DEPTH,
  parameter int DATA_WIDTH       = 8,
  parameter int ALMOST_FULL_LVL  = DATA_DEPTH - 4,
  parameter int ALMOST_EMPTY_LVL = 4,
  localparam int LVL_WIDTH       = level_width(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [LVL_WIDTH-1:0]  level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int ADDR_WIDTH = ptr_width(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [LVL_WIDTH-1:0]  FULL_LVL  = LVL_WIDTH'(DATA_DEPTH);

  if (DATA_DEPTH < 2 || !(ALMOST_EMPTY_LVL < ALMOST_FULL_LVL && ALMOST_FULL_LVL <= DATA_DEPTH))
  begin : g_bad_params
    $error("sync_fifo_fwft: illegal DATA_DEPTH/ALMOST_*_LVL combination");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
  logic                  pend_q, pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [LVL_WIDTH-1:0]  level_q, level_d;
  logic                  full_q, full_d, afull_q, afull_d;
  logic                  empty_q, empty_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;

  logic                  wr_acc, pop, ram_nonempty, load, issue;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  bram_sd #(
    .DATA_DEPTH (DATA_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_acc && !flush_i && !rst),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data_i),
    .rd_en_i   (issue && !flush_i && !rst),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  // pend_q marks a word sitting in the RAM read register waiting for the
  // output register; a new read is only issued once that slot drains.
  always_comb begin
    wr_acc       = wr_en_i && !full_q;
    pop          = out_valid_q && rd_ready_i;
    ram_nonempty = (wr_ptr_q != rd_ptr_q) || (wr_wrap_q != rd_wrap_q);
    load         = pend_q && (!out_valid_q || pop);
    issue        = ram_nonempty && (!pend_q || load);

    wr_ptr_d    = wr_ptr_q;
    wr_wrap_d   = wr_wrap_q;
    rd_ptr_d    = rd_ptr_q;
    rd_wrap_d   = rd_wrap_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    level_d     = level_q;

    if (wr_acc) begin
      if (wr_ptr_q == LAST_ADDR) begin
        wr_ptr_d  = '0;
        wr_wrap_d = !wr_wrap_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (issue) begin
      if (rd_ptr_q == LAST_ADDR) begin
        rd_ptr_d  = '0;
        rd_wrap_d = !rd_wrap_q;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    if (issue)     pend_d = 1'b1;
    else if (load) pend_d = 1'b0;

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_rd_data;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    if (wr_acc && !pop)      level_d = level_q + 1'b1;
    else if (!wr_acc && pop) level_d = level_q - 1'b1;

    full_d   = (level_d == FULL_LVL);
    empty_d  = (level_d == '0);
    afull_d  = (int'(level_d) >= ALMOST_FULL_LVL);
    aempty_d = (int'(level_d) <= ALMOST_EMPTY_LVL);
    ovf_d    = ovf_q || (wr_en_i && full_q);
    unf_d    = unf_q || (rd_ready_i && !out_valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q    <= '0;
      wr_wrap_q   <= 1'b0;
      rd_ptr_q    <= '0;
      rd_wrap_q   <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= (ALMOST_FULL_LVL <= 0);
      aempty_q    <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_wrap_q   <= wr_wrap_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_wrap_q   <= rd_wrap_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign rd_data_o      = out_data_q;
  assign rd_valid_o     = out_valid_q;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = aempty_q;
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule
